// File: rtl/trace_pkg.sv
// Shared types for the commit trace buffer.
// Session FSM encoding used by the capture controller.
package trace_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DONE
    } state_t;

endpackage

// File: rtl/trace_ram.sv
// Trace entry storage: one synchronous write port, one asynchronous read port.
// Kept apart so FPGA flows can map it onto distributed RAM.
module trace_ram #(
    parameter int  DEPTH   = 16,
    parameter type entry_t = logic,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  entry_t        wdata,
    input  logic [AW-1:0] raddr,
    output entry_t        rdata
);

    entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/commit_trace_buffer.sv
// Cycle-stamped commit trace capture with PC trigger, stop/wrap modes
// and a show-ahead valid/ready readout port.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int  XLEN  = 32,
    parameter int  DEPTH = 16,
    parameter int  TS_W  = 16,
    parameter int  WRAP  = 0,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] alu_in,
    input  logic            reg_write_in,
    input  logic            arm,
    input  logic            stop,
    input  logic            trig_en,
    input  logic [XLEN-1:0] trig_pc,
    input  logic            rd_ready,
    output logic            rd_valid,
    output logic [XLEN-1:0] rd_pc,
    output logic [XLEN-1:0] rd_instr,
    output logic [XLEN-1:0] rd_alu,
    output logic [TS_W-1:0] rd_ts,
    output logic [CW-1:0]   count,
    output logic            overflow,
    output logic            busy
);

    typedef struct packed {
        logic [TS_W-1:0] ts;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] alu;
    } entry_t;

    state_t          state;
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CW-1:0]   cnt;
    logic [TS_W-1:0] ts;
    logic            ovf;
    logic            busy_q;

    entry_t wdata;
    entry_t head;
    logic   full;
    logic   hit;
    logic   active;
    logic   full_stop;
    logic   we;
    logic   drop;
    logic   pop;

    assign rd_valid = (state == S_DONE) && (cnt != '0);

    // arm wins over everything, so it masks both write and pop
    always_comb begin
        full      = (cnt == CW'(DEPTH));
        hit       = reg_write_in && (pc_in == trig_pc);
        active    = (state == S_ARMED) || (state == S_CAPTURE);
        full_stop = (WRAP == 0) && (state == S_CAPTURE) && full;
        we        = !arm && (((state == S_ARMED) && trig_en && hit) ||
                    ((state == S_CAPTURE) && reg_write_in && !full_stop));
        drop      = we && full;
        pop       = !arm && rd_valid && rd_ready;
        wdata     = '{ts: ts, pc: pc_in, instr: instr_in, alu: alu_in};
    end

    trace_ram #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wptr),
        .wdata (wdata),
        .raddr (rptr),
        .rdata (head)
    );

    assign rd_pc    = rd_valid ? head.pc    : '0;
    assign rd_instr = rd_valid ? head.instr : '0;
    assign rd_alu   = rd_valid ? head.alu   : '0;
    assign rd_ts    = rd_valid ? head.ts    : '0;
    assign count    = cnt;
    assign overflow = ovf;
    assign busy     = busy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            wptr   <= '0;
            rptr   <= '0;
            cnt    <= '0;
            ts     <= '0;
            ovf    <= 1'b0;
            busy_q <= 1'b0;
        end else if (arm) begin
            state  <= S_ARMED;
            wptr   <= '0;
            rptr   <= '0;
            cnt    <= '0;
            ts     <= '0;
            ovf    <= 1'b0;
            busy_q <= 1'b1;
        end else begin
            if (we) begin
                wptr <= wptr + 1'b1;
            end
            if (pop || drop) begin
                rptr <= rptr + 1'b1;
            end
            if (we && !drop) begin
                cnt <= cnt + 1'b1;
            end else if (pop) begin
                cnt <= cnt - 1'b1;
            end
            if (drop) begin
                ovf <= 1'b1;
            end
            // saturating session clock
            if (active && !(&ts)) begin
                ts <= ts + 1'b1;
            end
            unique case (state)
                S_ARMED: begin
                    if (stop) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                    end else if (!trig_en || hit) begin
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (stop || full_stop) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (pop && (cnt == CW'(1))) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: a stop-mode and a wrap-mode instance
// driven in lockstep and checked against a queue-based reference model.
module tb_commit_trace_buffer;

    localparam int DEPTH = 16;
    localparam int MI = 0;
    localparam int MA = 1;
    localparam int MC = 2;
    localparam int MD = 3;

    typedef struct packed {
        logic [15:0] ts;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] alu;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        arm;
    logic        stop;
    logic        trig_en;
    logic        rw;
    logic        rd_ready;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] alu;
    logic [31:0] trig_pc;

    logic        s_valid, w_valid;
    logic [31:0] s_pc, s_instr, s_alu;
    logic [31:0] w_pc, w_instr, w_alu;
    logic [15:0] s_ts;
    logic [3:0]  w_ts;
    logic [4:0]  s_count, w_count;
    logic        s_ovf, w_ovf, s_busy, w_busy;

    int checks = 0;
    int errors = 0;

    ent_t mq[2][$];
    int   mst[2];
    int   mts[2];
    bit   movf[2];

    always #5 clk = ~clk;

    commit_trace_buffer #(
        .XLEN(32), .DEPTH(DEPTH), .TS_W(16), .WRAP(0)
    ) u_stop (
        .clk(clk), .reset(reset), .pc_in(pc), .instr_in(instr),
        .alu_in(alu), .reg_write_in(rw), .arm(arm), .stop(stop),
        .trig_en(trig_en), .trig_pc(trig_pc), .rd_ready(rd_ready),
        .rd_valid(s_valid), .rd_pc(s_pc), .rd_instr(s_instr),
        .rd_alu(s_alu), .rd_ts(s_ts), .count(s_count),
        .overflow(s_ovf), .busy(s_busy)
    );

    commit_trace_buffer #(
        .XLEN(32), .DEPTH(DEPTH), .TS_W(4), .WRAP(1)
    ) u_wrap (
        .clk(clk), .reset(reset), .pc_in(pc), .instr_in(instr),
        .alu_in(alu), .reg_write_in(rw), .arm(arm), .stop(stop),
        .trig_en(trig_en), .trig_pc(trig_pc), .rd_ready(rd_ready),
        .rd_valid(w_valid), .rd_pc(w_pc), .rd_instr(w_instr),
        .rd_alu(w_alu), .rd_ts(w_ts), .count(w_count),
        .overflow(w_ovf), .busy(w_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mclear(input int k);
        mq[k].delete();
        mts[k]  = 0;
        movf[k] = 1'b0;
    endtask

    task automatic mpush(input int k);
        ent_t e;
        if (mq[k].size() == DEPTH) begin
            void'(mq[k].pop_front());
            movf[k] = 1'b1;
        end
        e.ts    = 16'(mts[k]);
        e.pc    = pc;
        e.instr = instr;
        e.alu   = alu;
        mq[k].push_back(e);
    endtask

    // k=0: stop-when-full, 16-bit stamp; k=1: wrap, 4-bit stamp
    task automatic model_step(input int k);
        int tsmax;
        bit act;
        bit hit;
        tsmax = (k == 0) ? 65535 : 15;
        if (reset) begin
            mclear(k);
            mst[k] = MI;
            return;
        end
        if (arm) begin
            mclear(k);
            mst[k] = MA;
            return;
        end
        act = (mst[k] == MA) || (mst[k] == MC);
        hit = rw && (pc == trig_pc);
        case (mst[k])
            MA: begin
                if (trig_en && hit) mpush(k);
                if (stop) mst[k] = MD;
                else if (!trig_en || hit) mst[k] = MC;
            end
            MC: begin
                if (k == 0 && mq[k].size() == DEPTH) begin
                    mst[k] = MD;
                end else begin
                    if (rw) mpush(k);
                    if (stop) mst[k] = MD;
                end
            end
            MD: begin
                if (mq[k].size() > 0 && rd_ready) begin
                    void'(mq[k].pop_front());
                    if (mq[k].size() == 0) mst[k] = MI;
                end
            end
            default: begin
            end
        endcase
        if (act && mts[k] < tsmax) mts[k]++;
    endtask

    task automatic check_outputs();
        ent_t h;
        bit   v;
        v = (mst[0] == MD) && (mq[0].size() > 0);
        h = '0;
        if (v) h = mq[0][0];
        chk("s_valid", s_valid, v);
        chk("s_pc", s_pc, h.pc);
        chk("s_instr", s_instr, h.instr);
        chk("s_alu", s_alu, h.alu);
        chk("s_ts", s_ts, h.ts);
        chk("s_count", s_count, mq[0].size());
        chk("s_ovf", s_ovf, movf[0]);
        chk("s_busy", s_busy, (mst[0] == MA) || (mst[0] == MC));
        v = (mst[1] == MD) && (mq[1].size() > 0);
        h = '0;
        if (v) h = mq[1][0];
        chk("w_valid", w_valid, v);
        chk("w_pc", w_pc, h.pc);
        chk("w_instr", w_instr, h.instr);
        chk("w_alu", w_alu, h.alu);
        chk("w_ts", w_ts, h.ts);
        chk("w_count", w_count, mq[1].size());
        chk("w_ovf", w_ovf, movf[1]);
        chk("w_busy", w_busy, (mst[1] == MA) || (mst[1] == MC));
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic commit(input logic [31:0] p);
        rw    = 1'b1;
        pc    = p;
        instr = $urandom;
        alu   = $urandom;
        tick();
        rw = 1'b0;
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        int got;
        reset    = 1'b1;
        arm      = 1'b0;
        stop     = 1'b0;
        trig_en  = 1'b0;
        rw       = 1'b0;
        rd_ready = 1'b0;
        pc       = '0;
        instr    = '0;
        alu      = '0;
        trig_pc  = '0;
        for (int k = 0; k < 2; k++) begin
            mclear(k);
            mst[k] = MI;
        end
        #2;
        check_outputs();
        tick();
        tick();
        reset = 1'b0;
        tick();

        // stop vs wrap, free-running capture of 20 commits
        arm_pulse();
        tick();
        for (int i = 0; i < 20; i++) commit(32'(4 * i));
        tick();
        tick();
        chk("t1_stop_count", s_count, 16);
        chk("t1_stop_busy", s_busy, 0);
        chk("t1_wrap_ovf", w_ovf, 1);
        stop_pulse();
        chk("t1_wrap_count", w_count, 16);
        chk("t1_stop_ovf", s_ovf, 0);
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t1_s_pc", s_pc, 64'(4 * i));
            chk("t1_s_ts", s_ts, 64'(i + 1));
            chk("t1_w_pc", w_pc, 64'(16 + 4 * i));
            tick();
        end
        rd_ready = 1'b0;
        chk("t1_s_drained", s_valid, 0);
        chk("t1_w_drained", w_count, 0);

        // PC trigger plus reader backpressure 1,0,0,1
        trig_en = 1'b1;
        trig_pc = 32'h0C;
        arm_pulse();
        for (int i = 0; i < 8; i++) commit(32'(4 * i));
        stop_pulse();
        chk("t2_s_count", s_count, 5);
        chk("t2_w_count", w_count, 5);
        chk("t2_first_pc", s_pc, 32'h0C);
        got = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            rd_ready = (c % 4 == 0) || (c % 4 == 3);
            chk("t2_s_pc", s_pc, 64'(12 + 4 * got));
            chk("t2_w_pc", w_pc, 64'(12 + 4 * got));
            if (rd_ready) got++;
            tick();
        end
        rd_ready = 1'b0;
        chk("t2_pops", got, 5);
        chk("t2_idle", s_valid, 0);
        trig_en = 1'b0;

        // asynchronous reset mid-capture, then a fresh session
        arm_pulse();
        tick();
        for (int i = 0; i < 5; i++) commit(32'(32'h40 + 4 * i));
        chk("t3_pre_count", s_count, 5);
        #2;
        reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            mclear(k);
            mst[k] = MI;
        end
        check_outputs();
        chk("t3_rst_count", s_count, 0);
        chk("t3_rst_busy", w_busy, 0);
        tick();
        reset = 1'b0;
        arm_pulse();
        tick();
        commit(32'h80);
        commit(32'h84);
        stop_pulse();
        chk("t3_s_ts0", s_ts, 1);
        chk("t3_w_ts0", w_ts, 1);
        rd_ready = 1'b1;
        tick();
        tick();
        rd_ready = 1'b0;

        // arm+stop together, then stop together with a commit
        arm_pulse();
        tick();
        for (int i = 0; i < 3; i++) commit(32'(4 * i));
        arm  = 1'b1;
        stop = 1'b1;
        rw   = 1'b1;
        pc   = 32'h100;
        tick();
        arm  = 1'b0;
        stop = 1'b0;
        rw   = 1'b0;
        chk("t4_arm_stop_count", s_count, 0);
        chk("t4_arm_stop_busy", s_busy, 1);
        tick();
        stop = 1'b1;
        commit(32'h200);
        stop = 1'b0;
        chk("t4_stop_commit_count", s_count, 1);
        chk("t4_stop_commit_pc", s_pc, 32'h200);
        chk("t4_stop_busy", w_busy, 0);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;

        // randomized sessions
        for (int s = 0; s < 6; s++) begin
            trig_en = 1'($urandom % 2);
            trig_pc = 32'(4 * $urandom_range(0, 7));
            arm_pulse();
            for (int c = 0; c < 90; c++) begin
                rw       = ($urandom % 4) != 0;
                pc       = 32'(4 * $urandom_range(0, 7));
                instr    = $urandom;
                alu      = $urandom;
                stop     = (c == 50);
                rd_ready = ($urandom % 3) != 0;
                arm      = (s == 3) && (c == 70);
                tick();
            end
            rw       = 1'b0;
            stop     = 1'b0;
            arm      = 1'b0;
            rd_ready = 1'b1;
            for (int c = 0; c < 40; c++) tick();
            rd_ready = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
